// File: rtl/shot_controller_pkg.sv
// Shared definitions for the ball-thrower game sequencer.
//   phase_e       : FSM state encoding, also driven out on the phase port
//   DIR_* / BTN_* : bit positions of the buttons inside the internal vectors
//   BTN_PRESSED   : board buttons and aim-block direction levels are active-low
//   first_dir()   : fixed-priority pick among adjust events (lowest index wins)
package shot_controller_pkg;

    typedef enum logic [2:0] {
        PH_INIT   = 3'd0,
        PH_AIM    = 3'd1,
        PH_LAUNCH = 3'd2,
        PH_FLIGHT = 3'd3,
        PH_SETTLE = 3'd4,
        PH_OVER   = 3'd5
    } phase_e;

    localparam int NUM_DIR       = 4;
    localparam int NUM_BTN       = 5;
    localparam int DIR_ANGLEUP   = 0;
    localparam int DIR_ANGLEDOWN = 1;
    localparam int DIR_POWERUP   = 2;
    localparam int DIR_POWERDOWN = 3;
    localparam int BTN_FIRE      = 4;

    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    // angleup > angledown > powerup > powerdown
    function automatic logic [1:0] first_dir(input logic [NUM_DIR-1:0] ev);
        first_dir = 2'd0;
        for (int i = NUM_DIR - 1; i >= 0; i--) begin
            if (ev[i]) first_dir = 2'(i);
        end
    endfunction

endpackage

// File: rtl/shot_controller_debounce.sv
// button_debounce: 2-flop synchronizer plus stability counter for one raw
// active-low pushbutton.
//   clk, rst : system clock, synchronous active-high reset
//   btn_n    : raw asynchronous button (low = pressed)
//   level    : debounced level, resets to released (1)
//   fall     : one-cycle pulse in the cycle level goes to pressed
module button_debounce
    import shot_controller_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic fall
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the
    // debounced level; any agreement (a bounce back) restarts it.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                fall_d  = (sync2_q == BTN_PRESSED);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= BTN_RELEASED;
            sync2_q <= BTN_RELEASED;
            level_q <= BTN_RELEASED;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/shot_controller.sv
// shot_controller: sequences one game of the ball thrower.
//   clk, rst                 : system clock, synchronous active-high reset
//   angleup..powerdown, fire : raw active-low buttons
//   landed, hit              : physics status (hit sampled with first landed)
//   update, *_o, aim_rst     : strobe / active-low direction levels / reset to aim block
//   launch                   : one-cycle launch pulse to physics
//   phase, shots, score      : FSM state, shots fired, hits this game
//   game_over                : high in OVER
// All outputs are registered.
module shot_controller
    import shot_controller_pkg::*;
#(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 12500000,
    parameter int MAX_SHOTS     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       angleup,
    input  logic       angledown,
    input  logic       powerup,
    input  logic       powerdown,
    input  logic       fire,
    input  logic       landed,
    input  logic       hit,
    output logic       update,
    output logic       angleup_o,
    output logic       angledown_o,
    output logic       powerup_o,
    output logic       powerdown_o,
    output logic       aim_rst,
    output logic       launch,
    output logic [2:0] phase,
    output logic [2:0] shots,
    output logic [2:0] score,
    output logic       game_over
);

    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [NUM_BTN-1:0] btn_n, lvl, fall;
    assign btn_n = {fire, powerdown, powerup, angledown, angleup};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[i]),
            .level (lvl[i]),
            .fall  (fall[i])
        );
    end

    phase_e          state_q, state_d;
    logic [2:0]      ic_q, ic_d;          // INIT cycles already issued
    logic [3:0]      seq_q, seq_d;        // adjust sequence valid pipe, bit k = e+k+1
    logic [1:0]      sel_q, sel_d;
    logic            rep_act_q, rep_act_d;
    logic [1:0]      rep_dir_q, rep_dir_d;
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic            fire_pend_q, fire_pend_d;
    logic            update_q, update_d;
    logic [3:0]      dir_o_q, dir_o_d;
    logic            aim_rst_q, aim_rst_d;
    logic            launch_q, launch_d;
    logic [2:0]      shots_q, shots_d;
    logic [2:0]      score_q, score_d;
    logic            game_over_q, game_over_d;

    logic            in_aim, rep_evt, fire_go, adj_go;
    logic [3:0]      adj_ev;
    logic [1:0]      adj_dir;

    assign in_aim  = (state_q == PH_AIM);
    assign rep_evt = rep_act_q && (rep_cnt_q == RW'(REPEAT_CYCLES - 1))
                     && (lvl[rep_dir_q] == BTN_PRESSED);
    assign adj_ev  = fall[NUM_DIR-1:0] | (rep_evt ? (4'b0001 << rep_dir_q) : 4'b0000);
    assign adj_dir = first_dir(adj_ev);
    // Fire may hand over in the last busy cycle (only the e+4 update remains),
    // so a latched fire launches the cycle right after the sequence ends.
    assign fire_go = in_aim && (fall[BTN_FIRE] || fire_pend_q) && !(|seq_q[2:0]);
    assign adj_go  = in_aim && !(|seq_q) && !fire_go && (|adj_ev);

    always_comb begin
        state_d     = state_q;
        ic_d        = ic_q;
        seq_d       = {seq_q[2:0], adj_go};
        sel_d       = adj_go ? adj_dir : sel_q;
        rep_act_d   = rep_act_q;
        rep_dir_d   = rep_dir_q;
        rep_cnt_d   = (adj_go || rep_evt) ? '0 : rep_cnt_q + 1'b1;
        fire_pend_d = fire_pend_q;
        update_d    = seq_q[0] | seq_q[2];
        dir_o_d     = '1;
        aim_rst_d   = 1'b0;
        launch_d    = 1'b0;
        shots_d     = shots_q;
        score_d     = score_q;

        if (adj_go)                   dir_o_d[adj_dir] = BTN_PRESSED;
        else if (seq_q[0] | seq_q[1]) dir_o_d[sel_q]   = BTN_PRESSED;

        // Repeat timer follows the most recently accepted direction only.
        if (adj_go) begin
            rep_act_d = 1'b1;
            rep_dir_d = adj_dir;
        end else if (lvl[rep_dir_q] == BTN_RELEASED) begin
            rep_act_d = 1'b0;
        end

        unique case (state_q)
            PH_INIT: begin
                shots_d = '0;
                score_d = '0;
                if (ic_q == 3'd4) begin
                    state_d = PH_AIM;
                end else begin
                    aim_rst_d = 1'b1;
                    update_d  = ic_q[0];
                    ic_d      = ic_q + 3'd1;
                end
            end
            PH_AIM: begin
                if (fire_go) begin
                    state_d     = PH_LAUNCH;
                    launch_d    = 1'b1;
                    shots_d     = shots_q + 3'd1;
                    fire_pend_d = 1'b0;
                end else if (fall[BTN_FIRE]) begin
                    fire_pend_d = 1'b1;
                end
            end
            PH_LAUNCH: state_d = PH_FLIGHT;
            PH_FLIGHT: begin
                if (landed) begin
                    state_d = PH_SETTLE;
                    score_d = score_q + {2'b00, hit};
                end
            end
            PH_SETTLE: state_d = (shots_q == 3'(MAX_SHOTS)) ? PH_OVER : PH_AIM;
            PH_OVER: begin
                if (fall[BTN_FIRE]) begin
                    // Enter directly at INIT cycle 0 so INIT spans exactly 4 cycles.
                    state_d   = PH_INIT;
                    ic_d      = 3'd1;
                    aim_rst_d = 1'b1;
                    update_d  = 1'b0;
                    shots_d   = '0;
                    score_d   = '0;
                end
            end
            default: state_d = PH_INIT;
        endcase

        if (state_d != PH_AIM) begin
            fire_pend_d = 1'b0;
            rep_act_d   = 1'b0;
        end
        game_over_d = (state_d == PH_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PH_INIT;
            ic_q        <= '0;
            seq_q       <= '0;
            sel_q       <= '0;
            rep_act_q   <= 1'b0;
            rep_dir_q   <= '0;
            rep_cnt_q   <= '0;
            fire_pend_q <= 1'b0;
            update_q    <= 1'b0;
            dir_o_q     <= '1;
            aim_rst_q   <= 1'b0;
            launch_q    <= 1'b0;
            shots_q     <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ic_q        <= ic_d;
            seq_q       <= seq_d;
            sel_q       <= sel_d;
            rep_act_q   <= rep_act_d;
            rep_dir_q   <= rep_dir_d;
            rep_cnt_q   <= rep_cnt_d;
            fire_pend_q <= fire_pend_d;
            update_q    <= update_d;
            dir_o_q     <= dir_o_d;
            aim_rst_q   <= aim_rst_d;
            launch_q    <= launch_d;
            shots_q     <= shots_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
        end
    end

    assign update      = update_q;
    assign angleup_o   = dir_o_q[DIR_ANGLEUP];
    assign angledown_o = dir_o_q[DIR_ANGLEDOWN];
    assign powerup_o   = dir_o_q[DIR_POWERUP];
    assign powerdown_o = dir_o_q[DIR_POWERDOWN];
    assign aim_rst     = aim_rst_q;
    assign launch      = launch_q;
    assign phase       = state_q;
    assign shots       = shots_q;
    assign score       = score_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller: directed steps with randomized gaps/holds, an
// expected per-cycle trace built from the timing rules, plus spot checks.
module tb_shot_controller;

    localparam int DEB    = 4;
    localparam int REP    = 20;
    localparam int MAXS   = 2;
    localparam int EV_LAT = 2 + DEB;   // raw press to debounced press event
    localparam int DEPTH  = 1024;

    logic       clk = 1'b0;
    logic       rst, landed, hit;
    logic [4:0] btn;                   // 0 angleup, 1 angledown, 2 powerup, 3 powerdown, 4 fire
    logic       update, angleup_o, angledown_o, powerup_o, powerdown_o;
    logic       aim_rst, launch, game_over;
    logic [2:0] phase, shots, score;

    shot_controller #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP), .MAX_SHOTS(MAXS)) dut (
        .clk(clk), .rst(rst),
        .angleup(btn[0]), .angledown(btn[1]), .powerup(btn[2]), .powerdown(btn[3]),
        .fire(btn[4]), .landed(landed), .hit(hit),
        .update(update), .angleup_o(angleup_o), .angledown_o(angledown_o),
        .powerup_o(powerup_o), .powerdown_o(powerdown_o),
        .aim_rst(aim_rst), .launch(launch), .phase(phase), .shots(shots),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // recorded outputs, one entry per cycle
    logic       rec_upd [DEPTH], rec_launch [DEPTH], rec_arst [DEPTH], rec_go [DEPTH];
    logic [3:0] rec_o [DEPTH];
    logic [2:0] rec_phase [DEPTH], rec_shots [DEPTH], rec_score [DEPTH];

    always @(negedge clk) begin
        if (cyc < DEPTH) begin
            rec_upd[cyc]    = update;
            rec_o[cyc]      = {powerdown_o, powerup_o, angledown_o, angleup_o};
            rec_launch[cyc] = launch;
            rec_arst[cyc]   = aim_rst;
            rec_go[cyc]     = game_over;
            rec_phase[cyc]  = phase;
            rec_shots[cyc]  = shots;
            rec_score[cyc]  = score;
        end
    end

    // expected trace
    logic       exp_upd [DEPTH], exp_launch [DEPTH], exp_arst [DEPTH];
    logic [3:0] exp_o [DEPTH];

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One adjust sequence accepted at cycle e for direction d.
    task automatic m_seq(input int e, input int d);
        for (int c = e + 1; c <= e + 3; c++) exp_o[c][d] = 1'b0;
        exp_upd[e + 2] = 1'b1;
        exp_upd[e + 4] = 1'b1;
    endtask

    // Raw press driven at cycle c, held h cycles: first event, then one every
    // REP cycles while the debounced level is still low.
    task automatic m_press(input int d, input int c, input int h);
        int e;
        e = c + EV_LAT;
        for (int k = 0; REP * k < h; k++) m_seq(e + REP * k, d);
    endtask

    task automatic m_init(input int s);
        for (int c = s; c < s + 4; c++) exp_arst[c] = 1'b1;
        exp_upd[s + 1] = 1'b1;
        exp_upd[s + 3] = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c, h, t_rel, t_init, t_l1, t_s1, t_l2, t_s2, t_i, t_end;

        for (int i = 0; i < DEPTH; i++) begin
            exp_upd[i] = 1'b0; exp_launch[i] = 1'b0; exp_arst[i] = 1'b0; exp_o[i] = 4'hF;
        end
        rst = 1'b1; btn = 5'h1F; landed = 1'b0; hit = 1'b0;
        step(3);

        chk("rst_update",    update, 0);
        chk("rst_dir_o",     {powerdown_o, powerup_o, angledown_o, angleup_o}, 4'hF);
        chk("rst_aim_rst",   aim_rst, 0);
        chk("rst_launch",    launch, 0);
        chk("rst_phase",     phase, 0);
        chk("rst_shots",     shots, 0);
        chk("rst_score",     score, 0);
        chk("rst_game_over", game_over, 0);

        // reset release -> INIT
        rst = 1'b0; t_rel = cyc; t_init = t_rel + 1;
        m_init(t_init);
        step(8);

        // clean angleup press, ~10 cycles, no repeat
        step($urandom_range(2, 6));
        c = cyc; h = $urandom_range(8, 12);
        btn[0] = 1'b0; m_press(0, c, h); step(h); btn[0] = 1'b1;
        step(EV_LAT + 8);

        // angleup held ~50 cycles: press plus two repeats
        c = cyc; h = $urandom_range(45, 55);
        btn[0] = 1'b0; m_press(0, c, h); step(h); btn[0] = 1'b1;
        step(EV_LAT + 10);

        // powerup bouncing, then steady
        for (int i = 0; i < 3; i++) begin
            btn[2] = 1'b0; step(1); btn[2] = 1'b1; step(1);
        end
        c = cyc; h = $urandom_range(10, 14);
        btn[2] = 1'b0; m_press(2, c, h); step(h); btn[2] = 1'b1;
        step(EV_LAT + 8);

        // angleup and powerdown together: angleup wins, powerdown dropped
        c = cyc;
        btn[0] = 1'b0; btn[3] = 1'b0; m_press(0, c, 10); step(10);
        btn[0] = 1'b1; btn[3] = 1'b1;
        step(EV_LAT + 8);

        // shot 1: hit; angleup pressed during flight must be ignored
        c = cyc; t_l1 = c + EV_LAT + 1; exp_launch[t_l1] = 1'b1;
        btn[4] = 1'b0; step(6); btn[4] = 1'b1;
        step(2); btn[0] = 1'b0;
        step(7 + $urandom_range(0, 4));
        landed = 1'b1; hit = 1'b1; t_s1 = cyc + 1;
        step(1); hit = 1'b0;
        step(2); landed = 1'b0; btn[0] = 1'b1;
        step(EV_LAT + 8);

        // shot 2: miss -> OVER, landed left high in OVER
        c = cyc; t_l2 = c + EV_LAT + 1; exp_launch[t_l2] = 1'b1;
        btn[4] = 1'b0; step(6); btn[4] = 1'b1;
        step(3 + $urandom_range(0, 5));
        landed = 1'b1; hit = 1'b0; t_s2 = cyc + 1;
        step(4); landed = 1'b0;
        step(6);

        // fire in OVER -> INIT
        c = cyc; t_i = c + EV_LAT + 1; m_init(t_i);
        btn[4] = 1'b0; step(6); btn[4] = 1'b1;
        step(10);
        t_end = cyc;

        chk("init_phase0",     rec_phase[t_init], 0);
        chk("init_to_aim",     rec_phase[t_init + 4], 1);
        chk("init_shots",      rec_shots[t_init + 4], 0);
        chk("init_score",      rec_score[t_init + 4], 0);
        chk("s1_launch_phase", rec_phase[t_l1], 2);
        chk("s1_shots",        rec_shots[t_l1], 1);
        chk("s1_flight",       rec_phase[t_l1 + 1], 3);
        chk("s1_still_flight", rec_phase[t_s1 - 1], 3);
        chk("s1_settle",       rec_phase[t_s1], 4);
        chk("s1_score",        rec_score[t_s1], 1);
        chk("s1_back_aim",     rec_phase[t_s1 + 1], 1);
        chk("s1_aim_landed",   rec_phase[t_s1 + 3], 1);
        chk("s2_shots",        rec_shots[t_l2], 2);
        chk("s2_settle",       rec_phase[t_s2], 4);
        chk("s2_not_over_yet", rec_go[t_s2], 0);
        chk("s2_over",         rec_phase[t_s2 + 1], 5);
        chk("s2_game_over",    rec_go[t_s2 + 1], 1);
        chk("s2_final_shots",  rec_shots[t_s2 + 1], 2);
        chk("s2_final_score",  rec_score[t_s2 + 1], 1);
        chk("over_holds",      rec_phase[t_s2 + 3], 5);
        chk("re_init_phase",   rec_phase[t_i], 0);
        chk("re_init_shots",   rec_shots[t_i], 0);
        chk("re_init_score",   rec_score[t_i], 0);
        chk("re_init_go",      rec_go[t_i], 0);
        chk("re_init_aim",     rec_phase[t_i + 4], 1);

        for (int k = 1; k < t_end && k < DEPTH; k++) begin
            chk($sformatf("trace@%0d{upd,o,launch,arst}", k),
                {rec_upd[k], rec_o[k], rec_launch[k], rec_arst[k]},
                {exp_upd[k], exp_o[k], exp_launch[k], exp_arst[k]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
